// File: rtl/fma_pkg.sv
// Shared constants and helpers for the FMA normalise/round back end.
package fma_pkg;

  // Single-precision defaults.
  localparam int PARM_EXP_DEF  = 8;
  localparam int PARM_MANT_DEF = 23;

  // RISC-V frm encodings.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Bit positions inside the {NV,DZ,OF,UF,NX} fflags vector.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Width of the adder's magnitude output for a given fraction width.
  function automatic int fma_sum_width(input int mant);
    return 3 * mant + 5;
  endfunction

  // Round-increment decision; reserved frm encodings behave as RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (g | s) & sign;
      RM_RUP:  inc = (g | s) & ~sign;
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
    return inc;
  endfunction

  // On overflow: 1 selects infinity, 0 selects the largest finite value.
  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
    logic inf;
    case (rm)
      RM_RTZ:  inf = 1'b0;
      RM_RDN:  inf = sign;
      RM_RUP:  inf = ~sign;
      default: inf = 1'b1;
    endcase
    return inf;
  endfunction

endpackage

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter, counting from the MSB down.
module fma_lzc #(
  parameter  int WIDTH = 74,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    // NOTE: the default assignment ahead of the loop keeps this purely combinational (no latch).
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/fma_norm_round.sv
// FMA back end: normalise the adder magnitude, handle subnormal/overflow, round per frm
// and produce the packed IEEE-754 result with fflags. Two-stage valid/ready pipeline.
module fma_norm_round
  import fma_pkg::*;
#(
  parameter  int PARM_EXP  = PARM_EXP_DEF,
  parameter  int PARM_MANT = PARM_MANT_DEF,
  localparam int W         = fma_sum_width(PARM_MANT),
  localparam int RW        = PARM_EXP + PARM_MANT + 1
) (
  input  logic                  Clk_i,
  input  logic                  Rst_n_i,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  input  logic [W-1:0]          PosSum_i,
  input  logic [PARM_EXP+1:0]   Exp_i,
  input  logic                  Sign_i,
  input  logic                  Sticky_i,
  input  logic                  Special_i,
  input  logic [RW-1:0]         Special_result_i,
  input  logic [4:0]            Special_flags_i,
  input  logic [2:0]            Rnd_mode_i,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic [RW-1:0]         Result_o,
  output logic [4:0]            Fflags_o
);

  localparam int LZW = $clog2(W + 1);     // LZC count width
  localparam int EW  = PARM_EXP + 3;      // signed working exponent width
  localparam int MW  = PARM_MANT + 1;     // significand incl. hidden bit
  localparam int XW  = MW + 1;            // significand plus guard
  localparam int SHW = $clog2(XW + 1);    // subnormal shift amount width

  // ---------------- handshake ----------------
  logic r_s1_valid, r_s2_valid;
  logic w_s1_adv, w_s2_adv;

  assign w_s2_adv = ~r_s2_valid | Ready_i;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign Ready_o  = w_s1_adv;
  assign Valid_o  = r_s2_valid;

  // Stage valids advance whenever the stage ahead can take the entry.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (w_s1_adv) r_s1_valid <= Valid_i;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // ---------------- stage 1: capture + LZC ----------------
  logic [LZW-1:0] w_lzc;
  logic           w_zero;

  fma_lzc #(.WIDTH(W)) u_lzc (
    .i_data  (PosSum_i),
    .o_count (w_lzc),
    .o_zero  (w_zero)
  );

  logic [W-1:0]               r_s1_sum;
  logic signed [PARM_EXP+1:0] r_s1_exp;
  logic                       r_s1_sign, r_s1_sticky, r_s1_special, r_s1_zero;
  logic [RW-1:0]              r_s1_spec_res;
  logic [4:0]                 r_s1_spec_flags;
  logic [2:0]                 r_s1_rm;
  logic [LZW-1:0]             r_s1_lzc;

  // Capture an accepted operand set together with its leading-zero count.
  always_ff @(posedge Clk_i) begin
    // NOTE: payload registers carry no reset; they are only ever read under r_s1_valid.
    if (Valid_i && w_s1_adv) begin
      r_s1_sum        <= PosSum_i;
      r_s1_exp        <= Exp_i;
      r_s1_sign       <= Sign_i;
      r_s1_sticky     <= Sticky_i;
      r_s1_special    <= Special_i;
      r_s1_spec_res   <= Special_result_i;
      r_s1_spec_flags <= Special_flags_i;
      r_s1_rm         <= Rnd_mode_i;
      r_s1_lzc        <= w_lzc;
      r_s1_zero       <= w_zero;
    end
  end

  // ---------------- stage 2: normalise, round, pack ----------------
  logic [W-1:0]          w_norm;
  logic [MW-1:0]         w_sig;
  logic                  w_g, w_s;
  logic signed [EW-1:0]  w_e, w_sh_full;
  logic                  w_sub;
  logic [SHW-1:0]        w_sh;
  logic [2*XW-1:0]       w_shift_vec;

  assign w_norm      = r_s1_sum << r_s1_lzc;
  assign w_sig       = w_norm[W-1 -: MW];
  assign w_g         = w_norm[W-1-MW];
  assign w_s         = (|w_norm[W-2-MW:0]) | r_s1_sticky;
  // Leading one sits at W-2 for an LZC of 1, hence the +1.
  assign w_e         = {r_s1_exp[PARM_EXP+1], r_s1_exp} + EW'(1) - EW'(r_s1_lzc);
  assign w_sub       = w_e[EW-1] | (w_e == '0);
  assign w_sh_full   = EW'(1) - w_e;
  // Significand and guard move down together; everything below the new guard is sticky.
  assign w_shift_vec = {w_sig, w_g, {XW{1'b0}}} >> w_sh;

  // Denormalising shift, saturated once every significand bit is gone.
  always_comb begin
    w_sh = SHW'(XW);
    if (w_sh_full < EW'(XW)) w_sh = w_sh_full[SHW-1:0];
  end

  logic [MW-1:0]        w_rsig;
  logic                 w_rg, w_rs, w_inc, w_inc_unb, w_tiny, w_nx, w_ovf;
  logic [MW:0]          w_rsum;
  logic signed [EW-1:0] w_e_fin;
  logic [PARM_MANT-1:0] w_frac;
  logic [PARM_EXP-1:0]  w_exp_field;
  logic [RW-1:0]        w_result;
  logic [4:0]           w_fflags;

  // Round the (possibly denormalised) significand and select the final encoding.
  always_comb begin
    w_rsig = w_sig;
    w_rg   = w_g;
    w_rs   = w_s;
    if (w_sub) begin
      w_rsig = w_shift_vec[2*XW-1 -: MW];
      w_rg   = w_shift_vec[XW];
      w_rs   = w_s | (|w_shift_vec[XW-1:0]);
    end

    w_inc  = round_inc(r_s1_rm, r_s1_sign, w_rsig[0], w_rg, w_rs);
    w_rsum = {1'b0, w_rsig} + {{MW{1'b0}}, w_inc};

    w_e_fin     = w_e;
    w_frac      = w_rsum[PARM_MANT-1:0];
    w_exp_field = w_e[PARM_EXP-1:0];
    if (w_sub) begin
      // A carry into the hidden bit turns the subnormal into the smallest normal.
      w_exp_field = PARM_EXP'(w_rsum[MW-1]);
    end else if (w_rsum[MW]) begin
      w_e_fin     = w_e + EW'(1);
      w_frac      = w_rsum[PARM_MANT:1];
      w_exp_field = w_e_fin[PARM_EXP-1:0];
    end

    w_ovf = ~w_sub & (w_e_fin >= EW'((1 << PARM_EXP) - 1));

    // Tininess after rounding: only E==0 with a carry at full precision escapes.
    w_inc_unb = round_inc(r_s1_rm, r_s1_sign, w_sig[0], w_g, w_s);
    w_tiny    = w_sub & ~((w_e == '0) & w_inc_unb & (&w_sig));
    w_nx      = w_rg | w_rs | w_ovf;

    w_fflags = '0;
    if (r_s1_special) begin
      w_result = r_s1_spec_res;
      w_fflags = r_s1_spec_flags;
    end else if (r_s1_zero && !r_s1_sticky) begin
      w_result = {(r_s1_rm == RM_RDN), {(RW-1){1'b0}}};
    end else if (w_ovf) begin
      if (ovf_to_inf(r_s1_rm, r_s1_sign))
        w_result = {r_s1_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      else
        w_result = {r_s1_sign, {(PARM_EXP-1){1'b1}}, 1'b0, {PARM_MANT{1'b1}}};
      w_fflags[FLAG_OF] = 1'b1;
      w_fflags[FLAG_NX] = 1'b1;
    end else begin
      w_result          = {r_s1_sign, w_exp_field, w_frac};
      w_fflags[FLAG_NX] = w_nx;
      w_fflags[FLAG_UF] = w_nx & w_tiny;
    end
  end

  logic [RW-1:0] r_result;
  logic [4:0]    r_fflags;

  // Output register: loads only when stage 2 advances, so it holds under backpressure.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      r_result <= '0;
      r_fflags <= '0;
    end else if (r_s1_valid && w_s2_adv) begin
      r_result <= w_result;
      r_fflags <= w_fflags;
    end
  end

  assign Result_o = r_result;
  assign Fflags_o = r_fflags;

endmodule

// File: tb/tb_fma_norm_round.sv
// Directed, table-driven bench for fma_norm_round (single precision, W=74).
module tb_fma_norm_round;
  import fma_pkg::*;

  localparam int W  = 74;
  localparam int RW = 32;

  logic          Clk_i = 1'b0;
  logic          Rst_n_i;
  logic          Valid_i, Ready_o;
  logic [W-1:0]  PosSum_i;
  logic [9:0]    Exp_i;
  logic          Sign_i, Sticky_i, Special_i;
  logic [RW-1:0] Special_result_i;
  logic [4:0]    Special_flags_i;
  logic [2:0]    Rnd_mode_i;
  logic          Valid_o, Ready_i;
  logic [RW-1:0] Result_o;
  logic [4:0]    Fflags_o;

  always #5 Clk_i = ~Clk_i;

  fma_norm_round dut (
    .Clk_i            (Clk_i),
    .Rst_n_i          (Rst_n_i),
    .Valid_i          (Valid_i),
    .Ready_o          (Ready_o),
    .PosSum_i         (PosSum_i),
    .Exp_i            (Exp_i),
    .Sign_i           (Sign_i),
    .Sticky_i         (Sticky_i),
    .Special_i        (Special_i),
    .Special_result_i (Special_result_i),
    .Special_flags_i  (Special_flags_i),
    .Rnd_mode_i       (Rnd_mode_i),
    .Valid_o          (Valid_o),
    .Ready_i          (Ready_i),
    .Result_o         (Result_o),
    .Fflags_o         (Fflags_o)
  );

  typedef struct {
    string         name;
    logic [W-1:0]  sum;
    logic [9:0]    exp;
    logic          sign, sticky, special;
    logic [31:0]   sres;
    logic [4:0]    sflags;
    logic [2:0]    rm;
    logic [31:0]   eres;
    logic [4:0]    eflags;
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] rx_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Record every output transfer (stable between the driving posedge+1 and the next posedge).
  always @(negedge Clk_i)
    if (Rst_n_i && Valid_o && Ready_i) rx_q.push_back({Result_o, Fflags_o});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [W-1:0] sum, input int e,
                              input logic sg, input logic st, input logic sp,
                              input logic [31:0] sr, input logic [4:0] sf, input logic [2:0] rm,
                              input logic [31:0] er, input logic [4:0] ef);
    vec_t v;
    v.name = n; v.sum = sum; v.exp = 10'(e); v.sign = sg; v.sticky = st; v.special = sp;
    v.sres = sr; v.sflags = sf; v.rm = rm; v.eres = er; v.eflags = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    PosSum_i = v.sum; Exp_i = v.exp; Sign_i = v.sign; Sticky_i = v.sticky;
    Special_i = v.special; Special_result_i = v.sres; Special_flags_i = v.sflags;
    Rnd_mode_i = v.rm; Valid_i = 1'b1;
  endtask

  // Call just after a posedge; returns just after the posedge that accepted the vector.
  task automatic send(input vec_t v);
    int t = 0;
    drive(v);
    @(negedge Clk_i);
    while (!Ready_o && t < 50) begin
      @(negedge Clk_i);
      t++;
    end
    if (!Ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL send_%s: Ready_o stuck at 0 for %0d cycles", v.name, t);
    end
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int t = 0;
    while (rx_q.size() < n && t < 200) begin
      @(negedge Clk_i);
      t++;
    end
    if (rx_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0d results, want %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic check_rx(input int k, input vec_t v, input string tag);
    logic [36:0] e;
    if (k < rx_q.size()) begin
      e = rx_q[k];
      check({tag, v.name, "_res"},   e[36:5], v.eres);
      check({tag, v.name, "_flags"}, e[4:0],  v.eflags);
    end
  endtask

  initial begin
    logic [W-1:0] p_one, p_tie, p_odd, p_ovf, p_ones25, p_ones24, p_l60, p_subx;
    int sidx[4];

    Rst_n_i = 1'b0; Valid_i = 1'b0; Ready_i = 1'b1;
    PosSum_i = '0; Exp_i = '0; Sign_i = 1'b0; Sticky_i = 1'b0; Special_i = 1'b0;
    Special_result_i = '0; Special_flags_i = '0; Rnd_mode_i = RM_RNE;

    p_one    = 74'd1 << 72;
    p_tie    = p_one | (74'd1 << 48);
    p_odd    = p_one | (74'd1 << 49) | (74'd1 << 48);
    p_ovf    = 74'd1 << 73;
    p_ones25 = ((74'd1 << 25) - 74'd1) << 48;
    p_ones24 = ((74'd1 << 24) - 74'd1) << 49;
    p_l60    = 74'd1 << 60;
    p_subx   = p_one | (74'd1 << 47);

    //                 name            sum       exp  sg st sp sres          sf     rm       expected      flags
    vecs.push_back(mk("one",          p_one,    127, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h3F800000, 5'h00));
    vecs.push_back(mk("tie_rne",      p_tie,    127, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h3F800000, 5'h01));
    vecs.push_back(mk("tie_rup",      p_tie,    127, 0, 0, 0, 32'h0,        5'h00, RM_RUP, 32'h3F800001, 5'h01));
    vecs.push_back(mk("tie_rmm",      p_tie,    127, 0, 0, 0, 32'h0,        5'h00, RM_RMM, 32'h3F800001, 5'h01));
    vecs.push_back(mk("tie_rtz",      p_tie,    127, 0, 0, 0, 32'h0,        5'h00, RM_RTZ, 32'h3F800000, 5'h01));
    vecs.push_back(mk("tie_rdn_neg",  p_tie,    127, 1, 0, 0, 32'h0,        5'h00, RM_RDN, 32'hBF800001, 5'h01));
    vecs.push_back(mk("odd_rne",      p_odd,    127, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h3F800002, 5'h01));
    vecs.push_back(mk("ovf_rne",      p_ovf,    254, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h7F800000, 5'h05));
    vecs.push_back(mk("ovf_rtz",      p_ovf,    254, 0, 0, 0, 32'h0,        5'h00, RM_RTZ, 32'h7F7FFFFF, 5'h05));
    vecs.push_back(mk("ovf_neg_rup",  p_ovf,    254, 1, 0, 0, 32'h0,        5'h00, RM_RUP, 32'hFF7FFFFF, 5'h05));
    vecs.push_back(mk("ovf_neg_rdn",  p_ovf,    254, 1, 0, 0, 32'h0,        5'h00, RM_RDN, 32'hFF800000, 5'h05));
    vecs.push_back(mk("ovf_round",    p_ones25, 254, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h7F800000, 5'h05));
    vecs.push_back(mk("max_rtz",      p_ones25, 254, 0, 0, 0, 32'h0,        5'h00, RM_RTZ, 32'h7F7FFFFF, 5'h01));
    vecs.push_back(mk("sub_exact",    p_one,     -2, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00100000, 5'h00));
    vecs.push_back(mk("sub_inexact",  p_subx,    -2, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00100000, 5'h03));
    vecs.push_back(mk("sub_to_norm",  p_ones25,   0, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00800000, 5'h01));
    vecs.push_back(mk("sub_tiny_nrm", p_ones24,   0, 0, 1, 0, 32'h0,        5'h00, RM_RNE, 32'h00800000, 5'h03));
    vecs.push_back(mk("sub_rtz",      p_ones25,   0, 0, 0, 0, 32'h0,        5'h00, RM_RTZ, 32'h007FFFFF, 5'h03));
    vecs.push_back(mk("deep_rne",     p_one,   -100, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00000000, 5'h03));
    vecs.push_back(mk("deep_rup",     p_one,   -100, 0, 0, 0, 32'h0,        5'h00, RM_RUP, 32'h00000001, 5'h03));
    vecs.push_back(mk("deep_neg_rdn", p_one,   -100, 1, 0, 0, 32'h0,        5'h00, RM_RDN, 32'h80000001, 5'h03));
    vecs.push_back(mk("zero_rdn",     '0,         0, 0, 0, 0, 32'h0,        5'h00, RM_RDN, 32'h80000000, 5'h00));
    vecs.push_back(mk("zero_rne_neg", '0,         0, 1, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00000000, 5'h00));
    vecs.push_back(mk("special_nan",  p_one,    127, 0, 0, 1, 32'h7FC00000, 5'h10, RM_RNE, 32'h7FC00000, 5'h10));
    vecs.push_back(mk("special_dz",   '0,         0, 1, 0, 1, 32'hFF800000, 5'h08, RM_RDN, 32'hFF800000, 5'h08));
    vecs.push_back(mk("rm_reserved",  p_odd,    127, 0, 0, 0, 32'h0,        5'h00, 3'b111, 32'h3F800002, 5'h01));
    vecs.push_back(mk("lzc_13",       p_l60,    127, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h39800000, 5'h00));
    vecs.push_back(mk("neg_two",      p_one,    128, 1, 0, 0, 32'h0,        5'h00, RM_RNE, 32'hC0000000, 5'h00));
    vecs.push_back(mk("min_normal",   p_one,      1, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00800000, 5'h00));
    vecs.push_back(mk("sub_half",     p_one,      0, 0, 0, 0, 32'h0,        5'h00, RM_RNE, 32'h00400000, 5'h00));

    // Reset state.
    #12;
    check("rst_valid_o",  Valid_o,  1'b0);
    check("rst_result_o", Result_o, 32'h0);
    check("rst_fflags_o", Fflags_o, 5'h0);
    check("rst_ready_o",  Ready_o,  1'b1);
    @(posedge Clk_i); #1;
    Rst_n_i = 1'b1;

    // Latency: presented in one cycle, Valid_o two clock edges later.
    @(posedge Clk_i); #1;
    drive(vecs[0]);
    @(negedge Clk_i);
    check("lat_ready_o", Ready_o, 1'b1);
    @(posedge Clk_i); #1;
    Valid_i = 1'b0;
    @(negedge Clk_i);
    check("lat_valid_c1", Valid_o, 1'b0);
    @(negedge Clk_i);
    check("lat_valid_c2", Valid_o,  1'b1);
    check("lat_result",   Result_o, vecs[0].eres);
    check("lat_flags",    Fflags_o, vecs[0].eflags);
    @(posedge Clk_i); #1;
    rx_q.delete();

    // Table: back-to-back stream with Ready_i high, compared in order.
    foreach (vecs[i]) send(vecs[i]);
    wait_rx(vecs.size(), "table_drain");
    repeat (4) @(negedge Clk_i);
    check("table_count", rx_q.size(), vecs.size());
    foreach (vecs[i]) check_rx(i, vecs[i], "tbl_");

    // Backpressure: Ready_i low for five edges while four entries are offered.
    sidx = '{1, 2, 7, 13};
    @(posedge Clk_i); #1;
    rx_q.delete();
    Ready_i = 1'b0;
    send(vecs[sidx[0]]);
    send(vecs[sidx[1]]);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk_i);
      check("stall_ready_o", Ready_o,  1'b0);
      check("stall_valid_o", Valid_o,  1'b1);
      check("stall_hold",    Result_o, vecs[sidx[0]].eres);
      @(posedge Clk_i); #1;
    end
    Ready_i = 1'b1;
    send(vecs[sidx[2]]);
    send(vecs[sidx[3]]);
    wait_rx(4, "stream_drain");
    repeat (4) @(negedge Clk_i);
    check("stream_count", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) check_rx(k, vecs[sidx[k]], "strm_");

    // Asynchronous reset with both stages full.
    @(posedge Clk_i); #1;
    rx_q.delete();
    Ready_i = 1'b0;
    send(vecs[2]);
    send(vecs[7]);
    @(negedge Clk_i);
    check("prerst_valid_o", Valid_o, 1'b1);
    #2;
    Rst_n_i = 1'b0;
    #1;
    check("rst_async_valid",  Valid_o,  1'b0);
    check("rst_async_result", Result_o, 32'h0);
    @(posedge Clk_i);
    @(posedge Clk_i); #1;
    Rst_n_i = 1'b1;
    @(negedge Clk_i);
    check("postrst_ready_o", Ready_o, 1'b1);
    check("postrst_valid_o", Valid_o, 1'b0);
    @(posedge Clk_i); #1;
    Ready_i = 1'b1;
    repeat (4) @(negedge Clk_i);
    check("postrst_no_stale", rx_q.size(), 0);

    // Recovery after reset.
    @(posedge Clk_i); #1;
    send(vecs[6]);
    wait_rx(1, "recover_drain");
    check_rx(0, vecs[6], "rec_");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
